// File: rtl/flag_pkg.sv
// Shared types and constants for the interrupt flag shadow controller.
package flag_pkg;

    localparam int DEFAULT_SHADOW_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fsm_t;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

endpackage

// File: rtl/shadow_stack.sv
// DEPTH-entry LIFO of saved {C,Z} flags; no wrap-around, push has priority if both are asserted.
module shadow_stack
    import flag_pkg::*;
#(
    parameter int DEPTH = DEFAULT_SHADOW_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  flags_t        push_data,
    output flags_t        top_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t        mem_q [DEPTH];
    flags_t        mem_d [DEPTH];
    logic [CW-1:0] level_q;
    logic [CW-1:0] level_d;
    logic [CW-1:0] top_ptr;

    always_comb begin
        full     = (level_q == CW'(DEPTH));
        empty    = (level_q == '0);
        top_ptr  = level_q - CW'(1);
        top_data = empty ? '0 : mem_q[top_ptr[AW-1:0]];
        mem_d    = mem_q;
        level_d  = level_q;
        if (push && !full) begin
            mem_d[level_q[AW-1:0]] = push_data;
            level_d                = level_q + CW'(1);
        end else if (pop && !empty) begin
            level_d = level_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/flag_shadow_ctrl.sv
// Interrupt request FSM plus C/Z shadow save/restore driving the I, C and Z flag registers.
// Define INTR_SYNC_EN to pass INTR through a two-flop synchronizer before edge detection.
module flag_shadow_ctrl
    import flag_pkg::*;
#(
    parameter int DEPTH = DEFAULT_SHADOW_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          INTR,
    input  logic          I_FLAG,
    input  logic          C_IN,
    input  logic          Z_IN,
    input  logic          INT_TAKE,
    input  logic          RETI,
    input  logic          RETI_IE,
    output logic          INT_REQ,
    output logic          CLR_I,
    output logic          SET_I,
    output logic          C_LD,
    output logic          Z_LD,
    output logic          C_OUT,
    output logic          Z_OUT,
    output logic [CW-1:0] LEVEL,
    output logic          ERR
);

    logic intr_s;

`ifdef INTR_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = INTR;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign intr_s = sync2_q;
`else
    assign intr_s = INTR;
`endif

    fsm_t          state_q, state_d;
    logic          intr_hist_q, intr_hist_d;
    logic          pend_q, pend_d;
    logic          int_req_q, int_req_d;
    logic          clr_i_q, clr_i_d;
    logic          set_i_q, set_i_d;
    logic          c_ld_q, c_ld_d;
    logic          z_ld_q, z_ld_d;
    logic          c_out_q, c_out_d;
    logic          z_out_q, z_out_d;
    logic          err_q, err_d;

    logic          rise;
    logic          take_ok;
    logic          reti_ok;
    flags_t        push_data;
    flags_t        top_data;
    logic          stk_full;
    logic          stk_empty;
    logic [CW-1:0] stk_level;

    shadow_stack #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_stack (
        .clk       (CLK),
        .rst       (RST),
        .push      (take_ok),
        .pop       (reti_ok),
        .push_data (push_data),
        .top_data  (top_data),
        .full      (stk_full),
        .empty     (stk_empty),
        .level     (stk_level)
    );

    always_comb begin
        rise      = intr_s & ~intr_hist_q;
        take_ok   = INT_TAKE & (state_q == REQ) & ~stk_full;
        // A simultaneous INT_TAKE always wins; the RETI is dropped and flagged.
        reti_ok   = RETI & ~INT_TAKE & ~stk_empty;
        push_data = '{c: C_IN, z: Z_IN};

        intr_hist_d = intr_s;
        pend_d      = rise | (pend_q & ~take_ok);

        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_q && I_FLAG && !stk_full) state_d = REQ;
            REQ:     if (INT_TAKE || !I_FLAG)          state_d = IDLE;
            default: state_d = IDLE;
        endcase

        int_req_d = (state_d == REQ);
        clr_i_d   = take_ok;
        set_i_d   = reti_ok & RETI_IE;
        c_ld_d    = reti_ok;
        z_ld_d    = reti_ok;
        c_out_d   = reti_ok ? top_data.c : c_out_q;
        z_out_d   = reti_ok ? top_data.z : z_out_q;
        err_d     = (INT_TAKE & (state_q != REQ))
                  | (INT_TAKE & RETI)
                  | (RETI & ~INT_TAKE & stk_empty);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            intr_hist_q <= 1'b0;
            pend_q      <= 1'b0;
            int_req_q   <= 1'b0;
            clr_i_q     <= 1'b0;
            set_i_q     <= 1'b0;
            c_ld_q      <= 1'b0;
            z_ld_q      <= 1'b0;
            c_out_q     <= 1'b0;
            z_out_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            intr_hist_q <= intr_hist_d;
            pend_q      <= pend_d;
            int_req_q   <= int_req_d;
            clr_i_q     <= clr_i_d;
            set_i_q     <= set_i_d;
            c_ld_q      <= c_ld_d;
            z_ld_q      <= z_ld_d;
            c_out_q     <= c_out_d;
            z_out_q     <= z_out_d;
            err_q       <= err_d;
        end
    end

    assign INT_REQ = int_req_q;
    assign CLR_I   = clr_i_q;
    assign SET_I   = set_i_q;
    assign C_LD    = c_ld_q;
    assign Z_LD    = z_ld_q;
    assign C_OUT   = c_out_q;
    assign Z_OUT   = z_out_q;
    assign LEVEL   = stk_level;
    assign ERR     = err_q;

endmodule
